// File: rtl/lc3_mem_pkg.sv
// Shared types and device-register addresses for the LC-3 memory responder.
// The MMIO addresses are only decoded when LC3_MMIO_EN is defined.
package lc3_mem_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam word_t KBSR_ADDR = 16'hFE00;
  localparam word_t KBDR_ADDR = 16'hFE02;
  localparam word_t DSR_ADDR  = 16'hFE04;
  localparam word_t DDR_ADDR  = 16'hFE06;

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port synchronous word RAM, 2**AW x 16.
// Contents are never cleared by reset.
module lc3_mem_array
  import lc3_mem_pkg::*;
#(
  parameter int AW        = 16,
  parameter     INIT_FILE = ""
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  word_t         din,
  output word_t         dout
);

  word_t mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 read/write/R (WMFC) handshake.
// Define LC3_MMIO_EN to add the keyboard/display device registers at xFE00-xFE06.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int MEM_AW      = 16,
  parameter int WAIT_STATES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
`ifdef LC3_MMIO_EN
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  input  logic        disp_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
`endif
  output logic [15:0] rdata,
  output logic        R,
  output logic        err
);

  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                op_wr;
  word_t               addr_q;
  word_t               wdata_q;
  logic                access;
  logic                is_dev;
  logic                ram_we;
  logic [MEM_AW-1:0]   ram_addr;
  word_t               ram_dout;
  word_t               rd_val;

  assign access = (state == BUSY) && (cnt == '0);
  assign ram_we = access && op_wr && !is_dev;

  // The RAM sees the live address while idle so a zero-wait read has its data
  // ready by the access edge; afterwards the latched address takes over.
  assign ram_addr = (state == IDLE) ? addr[MEM_AW-1:0] : addr_q[MEM_AW-1:0];

  lc3_mem_array #(
    .AW        (MEM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .din   (wdata_q),
    .dout  (ram_dout)
  );

`ifdef LC3_MMIO_EN
  logic       kb_pending;
  logic [7:0] kb_q;

  assign is_dev = (addr_q == KBSR_ADDR) || (addr_q == KBDR_ADDR) ||
                  (addr_q == DSR_ADDR)  || (addr_q == DDR_ADDR);

  always_comb begin
    rd_val = ram_dout;
    case (addr_q)
      KBSR_ADDR: rd_val = {kb_pending, 15'h0};
      KBDR_ADDR: rd_val = {8'h0, kb_q};
      DSR_ADDR:  rd_val = {disp_ready, 15'h0};
      default:   rd_val = ram_dout;
    endcase
  end

  // A fresh key wins over a simultaneous KBDR read so no keystroke is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kb_pending <= 1'b0;
      kb_q       <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      disp_valid <= 1'b0;
      if (kb_valid) begin
        kb_pending <= 1'b1;
        kb_q       <= kb_data;
      end else if (access && !op_wr && (addr_q == KBDR_ADDR)) begin
        kb_pending <= 1'b0;
      end
      if (access && op_wr && (addr_q == DDR_ADDR)) begin
        disp_valid <= 1'b1;
        disp_data  <= wdata_q[7:0];
      end
    end
  end
`else
  logic unused_addr_q;

  assign is_dev        = 1'b0;
  assign rd_val        = ram_dout;
  assign unused_addr_q = ^addr_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      R       <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (read ^ write) begin
            op_wr   <= write;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= CW'(WAIT_STATES);
            state   <= BUSY;
          end else if (read & write) begin
            err <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
            R     <= 1'b1;
            if (!op_wr) rdata <= rd_val;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (!read && !write) begin
            state <= IDLE;
            R     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
